// File: rtl/axi_line_bridge_pkg.sv
// axi_line_bridge_pkg
//   Shared constants and the state encoding for axi_line_bridge.
//   SIZE_D          : beat size code for 64-bit beats (AXI size = {1'b0, SIZE_D}).
//   AXI_BURST_INCR  : AXI INCR burst type.
//   AXI_RESP_OKAY   : AXI OKAY response code.
//   state_e         : bridge FSM states.
package axi_line_bridge_pkg;

  localparam logic [1:0] SIZE_D         = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5,
    ST_DONE = 3'd6
  } state_e;

endpackage

// File: rtl/axi_line_bridge.sv
// axi_line_bridge
//   Serves one 512-bit cache line read or write at a time as a single AXI4
//   INCR burst of up to eight 64-bit beats.
//
//   Cache side : i_rw_valid/o_rw_ready (ready is a one-cycle done pulse),
//                i_rw_op (0 rd, 1 wr), i_rw_addr, i_rw_size, i_rw_blks
//                (beats-1), i_rw_wdata, o_rw_rdata (registered, held until
//                the next read is accepted).
//   Bus side   : AXI4 master AW/W/B and AR/R channels, fixed ID = AXI_ID.
//   Clock/reset: clk, rst (synchronous, active high).
//
//   Optional   : `define AXI_LINE_ERR_EN adds o_rw_err, set when any R or B
//                response of the current burst is not OKAY.
module axi_line_bridge
  import axi_line_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic         clk,
  input  logic         rst,
  // cache line request
  input  logic         i_rw_valid,
  output logic         o_rw_ready,
  input  logic         i_rw_op,
  input  logic [63:0]  i_rw_addr,
  input  logic [1:0]   i_rw_size,
  input  logic [7:0]   i_rw_blks,
  input  logic [511:0] i_rw_wdata,
  output logic [511:0] o_rw_rdata,
`ifdef AXI_LINE_ERR_EN
  output logic         o_rw_err,
`endif
  // AW
  output logic         o_axi_aw_valid,
  input  logic         i_axi_aw_ready,
  output logic [63:0]  o_axi_aw_addr,
  output logic [3:0]   o_axi_aw_id,
  output logic [7:0]   o_axi_aw_len,
  output logic [2:0]   o_axi_aw_size,
  output logic [1:0]   o_axi_aw_burst,
  // W
  output logic         o_axi_w_valid,
  input  logic         i_axi_w_ready,
  output logic [63:0]  o_axi_w_data,
  output logic [7:0]   o_axi_w_strb,
  output logic         o_axi_w_last,
  // B
  input  logic         i_axi_b_valid,
  output logic         o_axi_b_ready,
  input  logic [1:0]   i_axi_b_resp,
  // AR
  output logic         o_axi_ar_valid,
  input  logic         i_axi_ar_ready,
  output logic [63:0]  o_axi_ar_addr,
  output logic [3:0]   o_axi_ar_id,
  output logic [7:0]   o_axi_ar_len,
  output logic [2:0]   o_axi_ar_size,
  output logic [1:0]   o_axi_ar_burst,
  // R
  input  logic         i_axi_r_valid,
  output logic         o_axi_r_ready,
  input  logic [63:0]  i_axi_r_data,
  input  logic [1:0]   i_axi_r_resp,
  input  logic         i_axi_r_last
);

  state_e       r_state, w_next;
  logic [63:0]  r_addr;
  logic [1:0]   r_size;
  logic [7:0]   r_blks;
  logic [2:0]   r_cnt;
  logic [511:0] r_rdata;
  logic         w_accept;
  logic         w_wlast;

  assign w_accept = (r_state == ST_IDLE) && i_rw_valid;
  assign w_wlast  = ({5'd0, r_cnt} == r_blks);

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // next state; the op is captured by which address state is entered
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_rw_valid)                    w_next = i_rw_op ? ST_AW : ST_AR;
      ST_AR:   if (i_axi_ar_ready)                w_next = ST_R;
      ST_R:    if (i_axi_r_valid && i_axi_r_last) w_next = ST_DONE;
      ST_AW:   if (i_axi_aw_ready)                w_next = ST_W;
      ST_W:    if (i_axi_w_ready && w_wlast)      w_next = ST_B;
      ST_B:    if (i_axi_b_valid)                 w_next = ST_DONE;
      ST_DONE:                                    w_next = ST_IDLE;
      default:                                    w_next = ST_IDLE;
    endcase
  end

  // handshake outputs are pure state decodes, so they never glitch or drop early
  always_comb begin
    o_axi_ar_valid = 1'b0;
    o_axi_r_ready  = 1'b0;
    o_axi_aw_valid = 1'b0;
    o_axi_w_valid  = 1'b0;
    o_axi_b_ready  = 1'b0;
    o_rw_ready     = 1'b0;
    case (r_state)
      ST_AR:   o_axi_ar_valid = 1'b1;
      ST_R:    o_axi_r_ready  = 1'b1;
      ST_AW:   o_axi_aw_valid = 1'b1;
      ST_W:    o_axi_w_valid  = 1'b1;
      ST_B:    o_axi_b_ready  = 1'b1;
      ST_DONE: o_rw_ready     = 1'b1;
      default: ;
    endcase
  end

  // request latch, beat counter and read line assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_blks  <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= i_rw_addr;
        r_size <= i_rw_size;
        r_blks <= i_rw_blks;
        r_cnt  <= '0;
        if (!i_rw_op) r_rdata <= '0;
      end
      // only r_last ends a read; surplus beats keep landing in slot 7
      if (r_state == ST_R && i_axi_r_valid) begin
        r_rdata[{r_cnt, 6'd0} +: 64] <= i_axi_r_data;
        if (r_cnt != 3'd7) r_cnt <= r_cnt + 3'd1;
      end
      if (r_state == ST_W && i_axi_w_ready && !w_wlast)
        r_cnt <= r_cnt + 3'd1;
    end
  end

`ifdef AXI_LINE_ERR_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst)                                                 r_err <= 1'b0;
    else if (w_accept)                                       r_err <= 1'b0;
    else if (r_state == ST_R && i_axi_r_valid &&
             i_axi_r_resp != AXI_RESP_OKAY)                  r_err <= 1'b1;
    else if (r_state == ST_B && i_axi_b_valid &&
             i_axi_b_resp != AXI_RESP_OKAY)                  r_err <= 1'b1;
  end
  assign o_rw_err = r_err;
`else
  // responses are deliberately ignored in this build
  logic w_unused_resp;
  assign w_unused_resp = ^{i_axi_r_resp, i_axi_b_resp};
`endif

  assign o_rw_rdata     = r_rdata;

  assign o_axi_ar_addr  = r_addr;
  assign o_axi_ar_id    = AXI_ID;
  assign o_axi_ar_len   = r_blks;
  assign o_axi_ar_size  = {1'b0, r_size};
  assign o_axi_ar_burst = AXI_BURST_INCR;

  assign o_axi_aw_addr  = r_addr;
  assign o_axi_aw_id    = AXI_ID;
  assign o_axi_aw_len   = r_blks;
  assign o_axi_aw_size  = {1'b0, r_size};
  assign o_axi_aw_burst = AXI_BURST_INCR;

  // write beat mux; the initiator holds the line stable until the done pulse
  assign o_axi_w_data   = i_rw_wdata[{r_cnt, 6'd0} +: 64];
  assign o_axi_w_strb   = 8'hFF;
  assign o_axi_w_last   = w_wlast;

endmodule

// File: tb/tb_axi_line_bridge.sv
// Directed bench for axi_line_bridge: a small AXI slave model driven per
// cycle by drive_txn, with each test task comparing its own observations.
module tb_axi_line_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_rw_valid, i_rw_op;
  logic         o_rw_ready;
  logic [63:0]  i_rw_addr;
  logic [1:0]   i_rw_size;
  logic [7:0]   i_rw_blks;
  logic [511:0] i_rw_wdata, o_rw_rdata;
`ifdef AXI_LINE_ERR_EN
  logic         o_rw_err;
`endif
  logic         o_axi_aw_valid, i_axi_aw_ready;
  logic [63:0]  o_axi_aw_addr;
  logic [3:0]   o_axi_aw_id;
  logic [7:0]   o_axi_aw_len;
  logic [2:0]   o_axi_aw_size;
  logic [1:0]   o_axi_aw_burst;
  logic         o_axi_w_valid, i_axi_w_ready, o_axi_w_last;
  logic [63:0]  o_axi_w_data;
  logic [7:0]   o_axi_w_strb;
  logic         i_axi_b_valid, o_axi_b_ready;
  logic [1:0]   i_axi_b_resp;
  logic         o_axi_ar_valid, i_axi_ar_ready;
  logic [63:0]  o_axi_ar_addr;
  logic [3:0]   o_axi_ar_id;
  logic [7:0]   o_axi_ar_len;
  logic [2:0]   o_axi_ar_size;
  logic [1:0]   o_axi_ar_burst;
  logic         i_axi_r_valid, o_axi_r_ready, i_axi_r_last;
  logic [63:0]  i_axi_r_data;
  logic [1:0]   i_axi_r_resp;

  axi_line_bridge dut (
    .clk(clk), .rst(rst),
    .i_rw_valid(i_rw_valid), .o_rw_ready(o_rw_ready), .i_rw_op(i_rw_op),
    .i_rw_addr(i_rw_addr), .i_rw_size(i_rw_size), .i_rw_blks(i_rw_blks),
    .i_rw_wdata(i_rw_wdata), .o_rw_rdata(o_rw_rdata),
`ifdef AXI_LINE_ERR_EN
    .o_rw_err(o_rw_err),
`endif
    .o_axi_aw_valid(o_axi_aw_valid), .i_axi_aw_ready(i_axi_aw_ready),
    .o_axi_aw_addr(o_axi_aw_addr), .o_axi_aw_id(o_axi_aw_id),
    .o_axi_aw_len(o_axi_aw_len), .o_axi_aw_size(o_axi_aw_size),
    .o_axi_aw_burst(o_axi_aw_burst),
    .o_axi_w_valid(o_axi_w_valid), .i_axi_w_ready(i_axi_w_ready),
    .o_axi_w_data(o_axi_w_data), .o_axi_w_strb(o_axi_w_strb),
    .o_axi_w_last(o_axi_w_last),
    .i_axi_b_valid(i_axi_b_valid), .o_axi_b_ready(o_axi_b_ready),
    .i_axi_b_resp(i_axi_b_resp),
    .o_axi_ar_valid(o_axi_ar_valid), .i_axi_ar_ready(i_axi_ar_ready),
    .o_axi_ar_addr(o_axi_ar_addr), .o_axi_ar_id(o_axi_ar_id),
    .o_axi_ar_len(o_axi_ar_len), .o_axi_ar_size(o_axi_ar_size),
    .o_axi_ar_burst(o_axi_ar_burst),
    .i_axi_r_valid(i_axi_r_valid), .o_axi_r_ready(o_axi_r_ready),
    .i_axi_r_data(i_axi_r_data), .i_axi_r_resp(i_axi_r_resp),
    .i_axi_r_last(i_axi_r_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // observations from the last drive_txn
  int           ready_cyc, ar_cnt, aw_cnt, ar_first, aw_first, wk, rpulses, extra;
  logic [63:0]  cap_ar_addr, cap_aw_addr;
  logic [7:0]   cap_ar_len, cap_aw_len, wlast_mask, strb_and;
  logic [2:0]   cap_ar_size, cap_aw_size;
  logic [1:0]   cap_ar_burst;
  logic [3:0]   cap_ar_id;
  logic [63:0]  wcap [8];
  logic [511:0] rdata_cap;
  logic         err_cap;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    i_axi_ar_ready = 0; i_axi_aw_ready = 0; i_axi_w_ready = 0;
    i_axi_r_valid = 0; i_axi_r_data = '0; i_axi_r_resp = 0; i_axi_r_last = 0;
    i_axi_b_valid = 0; i_axi_b_resp = 0;
  endtask

  // Raises a request (cycle 0), plays slave until two cycles after the done
  // pulse, and returns at that point so a following call re-raises at ready+2.
  task automatic drive_txn(input logic op, input logic [63:0] addr,
                           input logic [7:0] blks, input logic [511:0] wline,
                           input int rbeats, input logic [511:0] rline,
                           input int bad_beat, input bit wtoggle,
                           input logic [1:0] bresp);
    bit ar_done = 0, w_done = 0, b_sent = 0;
    bit ar_hs, r_hs, aw_hs, w_hs, w_hs_last, b_hs;
    int rk = 0;
    ready_cyc = -1; ar_cnt = 0; aw_cnt = 0; ar_first = -1; aw_first = -1;
    wk = 0; rpulses = 0; extra = 0; wlast_mask = '0; strb_and = 8'hFF;
    rdata_cap = '0; err_cap = 1'bx;
    for (int i = 0; i < 8; i++) wcap[i] = '0;
    i_rw_valid = 1; i_rw_op = op; i_rw_addr = addr; i_rw_size = 2'b11;
    i_rw_blks = blks; i_rw_wdata = wline;
    for (int cyc = 0; cyc < 80; cyc++) begin
      i_axi_ar_ready = 1; i_axi_aw_ready = 1;
      i_axi_r_valid  = ar_done && (rk < rbeats);
      i_axi_r_data   = (rk < 8) ? rline[rk*64 +: 64] : 64'hDEAD;
      i_axi_r_last   = (rk == rbeats - 1);
      i_axi_r_resp   = (rk == bad_beat) ? 2'b10 : 2'b00;
      i_axi_w_ready  = wtoggle ? ((cyc % 2) == 1) : 1'b1;
      i_axi_b_valid  = w_done && !b_sent;
      i_axi_b_resp   = bresp;
      if (ready_cyc >= 0 && (o_rw_ready || o_axi_ar_valid || o_axi_aw_valid)) extra++;
      if (o_rw_ready) begin
        rpulses++;
        if (ready_cyc < 0) begin
          ready_cyc = cyc;
          rdata_cap = o_rw_rdata;
`ifdef AXI_LINE_ERR_EN
          err_cap = o_rw_err;
`endif
        end
        i_rw_valid = 0;
      end
      if (o_axi_ar_valid && ar_first < 0) begin
        ar_first = cyc; cap_ar_addr = o_axi_ar_addr; cap_ar_len = o_axi_ar_len;
        cap_ar_size = o_axi_ar_size; cap_ar_burst = o_axi_ar_burst; cap_ar_id = o_axi_ar_id;
      end
      if (o_axi_aw_valid && aw_first < 0) begin
        aw_first = cyc; cap_aw_addr = o_axi_aw_addr; cap_aw_len = o_axi_aw_len;
        cap_aw_size = o_axi_aw_size;
      end
      ar_hs = o_axi_ar_valid && i_axi_ar_ready;
      r_hs  = o_axi_r_ready && i_axi_r_valid;
      aw_hs = o_axi_aw_valid && i_axi_aw_ready;
      w_hs  = o_axi_w_valid && i_axi_w_ready;
      w_hs_last = w_hs && o_axi_w_last;
      b_hs  = o_axi_b_ready && i_axi_b_valid;
      if (w_hs) begin
        if (wk < 8) begin
          wcap[wk] = o_axi_w_data;
          wlast_mask[wk] = o_axi_w_last;
        end
        strb_and = strb_and & o_axi_w_strb;
      end
      if (ready_cyc >= 0 && cyc == ready_cyc + 2) break;
      tick();
      if (ar_hs) begin ar_done = 1; ar_cnt++; end
      if (r_hs) rk++;
      if (aw_hs) aw_cnt++;
      if (w_hs) wk++;
      if (w_hs_last) w_done = 1;
      if (b_hs) b_sent = 1;
    end
    i_rw_valid = 0;
    idle_bus();
  endtask

  function automatic logic [511:0] line_of(input logic [63:0] base, input logic [63:0] step,
                                           input int n);
    logic [511:0] l = '0;
    for (int k = 0; k < n; k++) l[k*64 +: 64] = base + step * k;
    return l;
  endfunction

  logic [511:0] exp_full;

  task automatic test_reset();
    rst = 1; i_rw_valid = 0; i_rw_op = 0; i_rw_addr = '0; i_rw_size = 0;
    i_rw_blks = 0; i_rw_wdata = '0; idle_bus();
    tick(); tick();
    checks++;
    if ({o_axi_ar_valid, o_axi_aw_valid, o_axi_w_valid, o_axi_r_ready, o_axi_b_ready, o_rw_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_handshakes got=%b exp=000000",
               {o_axi_ar_valid, o_axi_aw_valid, o_axi_w_valid, o_axi_r_ready, o_axi_b_ready, o_rw_ready});
    end
    checks++;
    if (o_rw_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", o_rw_rdata); end
    rst = 0;
    tick();
  endtask

  task automatic test_read_full();
    exp_full = line_of(64'h11, 64'h11, 8);
    drive_txn(0, 64'h8000_0040, 8'd7, '0, 8, exp_full, -1, 0, 2'b00);
    checks++; if (ready_cyc !== 10) begin failures++; $display("FAIL rd_ready_cyc got=%0d exp=10", ready_cyc); end
    checks++; if (ar_first !== 1) begin failures++; $display("FAIL rd_ar_cyc got=%0d exp=1", ar_first); end
    checks++; if (cap_ar_addr !== 64'h8000_0040) begin failures++; $display("FAIL rd_ar_addr got=%h exp=80000040", cap_ar_addr); end
    checks++; if (cap_ar_len !== 8'd7) begin failures++; $display("FAIL rd_ar_len got=%0d exp=7", cap_ar_len); end
    checks++; if (cap_ar_size !== 3'd3) begin failures++; $display("FAIL rd_ar_size got=%0d exp=3", cap_ar_size); end
    checks++; if ({cap_ar_burst, cap_ar_id} !== 6'b01_0000) begin failures++; $display("FAIL rd_ar_burst_id got=%b exp=010000", {cap_ar_burst, cap_ar_id}); end
    checks++; if (rdata_cap !== exp_full) begin failures++; $display("FAIL rd_line got=%h exp=%h", rdata_cap, exp_full); end
    checks++; if (o_rw_rdata !== exp_full) begin failures++; $display("FAIL rd_line_hold got=%h exp=%h", o_rw_rdata, exp_full); end
    checks++; if ({rpulses, extra, ar_cnt, aw_cnt} !== {32'd1, 32'd0, 32'd1, 32'd0}) begin
      failures++; $display("FAIL rd_counts got=pulses%0d extra%0d ar%0d aw%0d exp=1 0 1 0", rpulses, extra, ar_cnt, aw_cnt);
    end
  endtask

  task automatic test_write_toggle();
    logic [511:0] wl;
    wl = line_of(64'd1, 64'd1, 8);
    drive_txn(1, 64'h8000_0080, 8'd7, wl, 0, '0, -1, 1, 2'b00);
    checks++; if (wk !== 8) begin failures++; $display("FAIL wr_beats got=%0d exp=8", wk); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (wcap[k] !== 64'(k + 1)) begin failures++; $display("FAIL wr_beat%0d got=%h exp=%h", k, wcap[k], 64'(k + 1)); end
    end
    checks++; if (wlast_mask !== 8'h80) begin failures++; $display("FAIL wr_last_mask got=%b exp=10000000", wlast_mask); end
    checks++; if (strb_and !== 8'hFF) begin failures++; $display("FAIL wr_strb got=%h exp=ff", strb_and); end
    checks++; if (ready_cyc !== 19) begin failures++; $display("FAIL wr_ready_cyc got=%0d exp=19", ready_cyc); end
    checks++; if ({cap_aw_addr, cap_aw_len, cap_aw_size} !== {64'h8000_0080, 8'd7, 3'd3}) begin
      failures++; $display("FAIL wr_aw_fields got=%h/%0d/%0d exp=80000080/7/3", cap_aw_addr, cap_aw_len, cap_aw_size);
    end
    checks++; if ({rpulses, ar_cnt, aw_cnt} !== {32'd1, 32'd0, 32'd1}) begin
      failures++; $display("FAIL wr_counts got=pulses%0d ar%0d aw%0d exp=1 0 1", rpulses, ar_cnt, aw_cnt);
    end
    checks++; if (o_rw_rdata !== exp_full) begin failures++; $display("FAIL wr_rdata_hold got=%h exp=%h", o_rw_rdata, exp_full); end
  endtask

  task automatic test_read_short();
    logic [511:0] rl;
    rl = line_of(64'hA0, 64'h1, 4);
    drive_txn(0, 64'h0000_1000, 8'd3, '0, 4, rl, -1, 0, 2'b00);
    checks++; if (ready_cyc !== 6) begin failures++; $display("FAIL rs_ready_cyc got=%0d exp=6", ready_cyc); end
    checks++; if (cap_ar_len !== 8'd3) begin failures++; $display("FAIL rs_ar_len got=%0d exp=3", cap_ar_len); end
    checks++; if (rdata_cap !== rl) begin failures++; $display("FAIL rs_line got=%h exp=%h", rdata_cap, rl); end
  endtask

  task automatic test_back_to_back();
    drive_txn(0, 64'h8000_0000, 8'd7, '0, 8, exp_full, -1, 0, 2'b00);
    checks++; if ({ready_cyc, extra} !== {32'd10, 32'd0}) begin
      failures++; $display("FAIL b2b_rd got=ready%0d extra%0d exp=10 0", ready_cyc, extra);
    end
    drive_txn(1, 64'h8000_0100, 8'd7, line_of(64'h50, 64'h1, 8), 0, '0, -1, 0, 2'b00);
    checks++; if ({ready_cyc, extra, ar_cnt, aw_cnt, wk} !== {32'd11, 32'd0, 32'd0, 32'd1, 32'd8}) begin
      failures++; $display("FAIL b2b_wr got=ready%0d extra%0d ar%0d aw%0d w%0d exp=11 0 0 1 8",
                           ready_cyc, extra, ar_cnt, aw_cnt, wk);
    end
    checks++; if (wcap[7] !== 64'h57) begin failures++; $display("FAIL b2b_wr_beat7 got=%h exp=57", wcap[7]); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    i_rw_valid = 1; i_rw_op = 1; i_rw_addr = 64'h2000; i_rw_size = 2'b11;
    i_rw_blks = 8'd7; i_rw_wdata = line_of(64'd1, 64'd1, 8);
    i_axi_aw_ready = 1; i_axi_w_ready = 1;
    for (int c = 0; c < 5; c++) tick();   // now cycle 5: W beat 3 on the bus
    checks++;
    if ({o_axi_w_valid, o_axi_w_data} !== {1'b1, 64'd4}) begin
      failures++; $display("FAIL rm_beat3 got=%b/%h exp=1/4", o_axi_w_valid, o_axi_w_data);
    end
    rst = 1; i_rw_valid = 0;
    tick();
    rst = 0;
    checks++;
    if ({o_axi_ar_valid, o_axi_aw_valid, o_axi_w_valid, o_axi_r_ready, o_axi_b_ready, o_rw_ready} !== 6'b0) begin
      failures++; $display("FAIL rm_after_rst got=%b exp=000000",
               {o_axi_ar_valid, o_axi_aw_valid, o_axi_w_valid, o_axi_r_ready, o_axi_b_ready, o_rw_ready});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_rw_ready || o_axi_aw_valid || o_axi_w_valid || o_axi_ar_valid) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rm_quiet got=%0d exp=0", bad); end
    idle_bus();
    drive_txn(0, 64'h3000, 8'd3, '0, 4, line_of(64'hC0, 64'h1, 4), -1, 0, 2'b00);
    checks++; if (ready_cyc !== 6) begin failures++; $display("FAIL rm_recover_ready got=%0d exp=6", ready_cyc); end
  endtask

`ifdef AXI_LINE_ERR_EN
  task automatic test_err();
    drive_txn(0, 64'h4000, 8'd7, '0, 8, exp_full, 5, 0, 2'b00);
    checks++; if (err_cap !== 1'b1) begin failures++; $display("FAIL err_rresp got=%b exp=1", err_cap); end
    drive_txn(0, 64'h4040, 8'd3, '0, 4, exp_full, -1, 0, 2'b00);
    checks++; if (err_cap !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err_cap); end
    drive_txn(1, 64'h4080, 8'd1, exp_full, 0, '0, -1, 0, 2'b10);
    checks++; if (err_cap !== 1'b1) begin failures++; $display("FAIL err_bresp got=%b exp=1", err_cap); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_full();
    test_write_toggle();
    test_read_short();
    test_back_to_back();
    test_reset_mid();
`ifdef AXI_LINE_ERR_EN
    test_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_line_bridge.md
# axi_line_bridge

Responder for the cache line request interface: accepts one 512-bit line read or write from the cache AXI unit and performs it as a single AXI4 INCR burst of up to eight 64-bit beats. It sits between the cache AXI unit and the SoC AXI bus. It is the AXI master on the bus side and the handshake responder on the cache side. It serves one line at a time: no outstanding-transaction overlap, no reordering.

## Interface
- AXI_ID, default 4'd0: constant ARID/AWID driven on every burst.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_rw_valid  in  1  line request; held high by the initiator until it sees o_rw_ready.
- o_rw_ready  out  1  one-cycle completion pulse.
- i_rw_op  in  1  0 read, 1 write.
- i_rw_addr  in  64  burst start byte address, 64-byte aligned.
- i_rw_size  in  2  beat size code, `SIZE_D` (64-bit) in normal use.
- i_rw_blks  in  8  beats minus one (0..7).
- i_rw_wdata  in  512  write line; beat k = [64k+63:64k].
- o_rw_rdata  out  512  read line; beat k = [64k+63:64k].
- AW channel: o_axi_aw_valid out 1, i_axi_aw_ready in 1, o_axi_aw_addr out 64, o_axi_aw_id out 4, o_axi_aw_len out 8, o_axi_aw_size out 3, o_axi_aw_burst out 2.
- W channel: o_axi_w_valid out 1, i_axi_w_ready in 1, o_axi_w_data out 64, o_axi_w_strb out 8, o_axi_w_last out 1.
- B channel: i_axi_b_valid in 1, o_axi_b_ready out 1, i_axi_b_resp in 2.
- AR channel: o_axi_ar_valid out 1, i_axi_ar_ready in 1, o_axi_ar_addr out 64, o_axi_ar_id out 4, o_axi_ar_len out 8, o_axi_ar_size out 3, o_axi_ar_burst out 2.
- R channel: i_axi_r_valid in 1, o_axi_r_ready out 1, i_axi_r_data in 64, i_axi_r_resp in 2, i_axi_r_last in 1.

## Operation
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE: on i_rw_valid, latch addr, op, size and blks, and clear the beat counter. For op=0, also clear o_rw_rdata to 0 and go to AR. For op=1, go to AW.
- AR, AW: drive the valid output with addr, len=blks, size={1'b0,size}, burst=INCR (2'b01). On handshake go to R or W respectively.
- R: o_axi_r_ready=1. Each accepted beat writes r_data into beat slot cnt, then cnt increments. Termination is on r_last only. cnt saturates at 7, so extra beats overwrite slot 7. An r_last arriving before cnt==blks still ends the burst; unreceived slots stay 0. Then go to DONE.
- W: w_data = line beat cnt, strb=8'hFF, w_last=(cnt==blks). cnt advances on each w handshake. Go to B after the last handshake.
- B: o_axi_b_ready=1. On b_valid go to DONE.
- DONE: o_rw_ready=1 for exactly one cycle, then IDLE.
- o_rw_rdata is registered and holds its value until the next read is accepted.
- Because IDLE is always entered after DONE, a request still high in the cycle after the ready pulse is evaluated as a new request. The initiator drops valid at that edge.

## Timing
- Reset: every AXI valid/ready output is 0, o_rw_ready=0, o_rw_rdata=0, state=IDLE, cnt=0.
- Read latency: request seen at cycle 0 → ar_valid at cycle 1. For a zero-wait slave: ar handshake at 1, beats at 2..9, ready pulse at cycle 10 for 8 beats.
- Write latency: aw at 1, w beats at 2..9, b at 10 (zero-wait), ready at 11.
- AXI valids are held stable until handshake and never drop early. Payload is constant while valid is high.
- rst asserted mid-burst: back to IDLE next edge with all valids low. The bus is assumed to be reset by the same signal.

## Configuration
- AXI_LINE_ERR_EN defined: adds output o_rw_err (1 bit, reset 0).
  - It is set when any r_resp or b_resp of the current burst is non-zero.
  - It is valid with the o_rw_ready pulse and cleared when the next request is accepted.
- Undefined: the port is absent and responses are ignored.

## Structure
- defines.v holds:
  - `SIZE_D`;
  - new constants `AXI_BURST_INCR`, `AXI_RESP_OKAY`;
  - state encodings.
- Single module with no sub-module. Beat muxing and assembly use indexed part-selects on cnt.

## Test plan
- Read, addr 0x8000_0040, blks 7, slave returns 0x11..0x88 per beat, zero wait → ar_len=7, ar_size=3, rdata beats in order, ready at cycle 10.
- Write, wdata beat k = k+1, blks 7, w_ready toggling every other cycle → 8 beats in order, w_last only on beat 7, one ready after b.
- Read, blks 3, 4 beats ending with r_last → slots 0..3 filled, slots 4..7 zero.
- Back-to-back: read then write with valid re-raised at ready+2 → no extra transaction, both complete.
- rst asserted during W beat 3 → all valids 0 next cycle, state IDLE, no ready pulse.
- With AXI_LINE_ERR_EN: r_resp=2'b10 on beat 5 → o_rw_err=1 with ready; next OKAY request → o_rw_err=0.
